// File: rtl/upd_1771c.sv
// upd_1771c -- simplified NEC uPD1771C sound generator for the Super Cassette
// Vision audio path.
//
// The host writes command packets one byte at a time on port A. Port B
// carries the active-low nCS/nWR strobes and returns the DSB handshake
// bit. The block produces a volume-scaled square wave on SND, an 8-bit
// unsigned sample centred on 8'h80.
//
// Packets (the command byte counts toward the length):
//   02, ctrl, period, volume : ctrl[7] = enable, P = period, V = volume[4:0]
//   00                       : silence
//   01, volume               : noise mode (UPD1771C_NOISE_EN builds only)
//
// Optional feature macro: UPD1771C_NOISE_EN
//   Defined     -> cmd 01 selects a 15-bit LFSR (x^15+x^14+1) in place of
//                  the square-wave phase.
//   Not defined -> cmd 01 is ignored like any other unknown command, and no
//                  LFSR logic is built.
//
// Ports
//   CLK    in   1  system clock (6 MHz nominal)
//   RES    in   1  synchronous active-high reset
//   CH1    in   1  clock-mode strap (ignored)
//   CH2    in   1  clock-mode strap (ignored)
//   PA_I   in   8  host data byte
//   PA_O   out  8  always 0
//   PA_OE  out  8  always 0; port A is input-only
//   PB_I   in   8  [7]=nCS, [6]=nWR (active-low); [5:0] ignored
//   PB_O   out  8  {7'b0, DSB}
//   PB_OE  out  8  always 8'h01
//   SND    out  8  audio sample
module upd_1771c #(
  parameter int PRESCALE  = 32,
  parameter int ACK_DELAY = 16
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       CH1,
  input  logic       CH2,
  input  logic [7:0] PA_I,
  output logic [7:0] PA_O,
  output logic [7:0] PA_OE,
  input  logic [7:0] PB_I,
  output logic [7:0] PB_O,
  output logic [7:0] PB_OE,
  output logic [7:0] SND
);

  localparam int PW = (PRESCALE  > 1) ? $clog2(PRESCALE)  : 1;
  localparam int AW = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REQ} state_t;

  state_t       r_state, w_next;

  // strobe synchronizer; the flops idle high, which is the inactive level
  logic         r_ncs_m, r_ncs_s, r_nwr_m, r_nwr_s, r_wr_d;
  logic         w_wr, w_strobe;

  // packet assembly
  logic [7:0]   r_cmd;
  logic [2:0]   r_len;       // total bytes in the packet, command included
  logic [2:0]   r_idx;       // bytes received so far
  logic [7:0]   r_buf [3];   // payload bytes after the command
  logic [AW-1:0] r_ack;
  logic [2:0]   w_len;
  logic         w_known, w_ack_done, w_commit, w_dsb;

  // tone generator
  logic         r_en;
  logic [7:0]   r_p;
  logic [4:0]   r_v;
  logic [PW-1:0] r_pre;
  logic [7:0]   r_pcnt;
  logic         r_phase;
  logic         w_tick, w_ph;
  logic [7:0]   r_snd;
`ifdef UPD1771C_NOISE_EN
  logic         r_noise;
  logic [14:0]  r_lfsr;
`endif

  assign PA_O  = 8'h00;
  assign PA_OE = 8'h00;
  assign PB_OE = 8'h01;
  assign PB_O  = {7'b0, w_dsb};
  assign SND   = r_snd;

  // Straps, unused port B bits and unused payload bits are ignored.
  wire w_unused_ok = &{1'b0, CH1, CH2, PB_I[5:0], r_buf[0][6:0], r_buf[2][7:5]};

  // ---------------------------------------------------------------- strobe
  always_ff @(posedge CLK) begin
    if (RES) begin
      r_ncs_m <= 1'b1;
      r_ncs_s <= 1'b1;
      r_nwr_m <= 1'b1;
      r_nwr_s <= 1'b1;
      r_wr_d  <= 1'b0;
    end else begin
      r_ncs_m <= PB_I[7];
      r_ncs_s <= r_ncs_m;
      r_nwr_m <= PB_I[6];
      r_nwr_s <= r_nwr_m;
      r_wr_d  <= w_wr;
    end
  end

  assign w_wr     = ~r_ncs_s & ~r_nwr_s;
  assign w_strobe = w_wr & ~r_wr_d;

  // ------------------------------------------------------- command decode
  always_comb begin
    w_len   = 3'd0;
    w_known = 1'b0;
    case (PA_I)
      8'h02: begin w_len = 3'd4; w_known = 1'b1; end
      8'h00: begin w_len = 3'd1; w_known = 1'b1; end
`ifdef UPD1771C_NOISE_EN
      8'h01: begin w_len = 3'd2; w_known = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign w_ack_done = (r_ack == AW'(ACK_DELAY - 1));
  // The final byte's ACK_DELAY wait ends in a commit instead of a request.
  assign w_commit   = (r_state == S_WAIT) && w_ack_done && (r_idx == r_len);

  // ------------------------------------------------------- FSM: state reg
  always_ff @(posedge CLK) begin
    if (RES) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // ------------------------------------------------------ FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_strobe && w_known) w_next = S_WAIT;
      S_WAIT: if (w_ack_done) w_next = (r_idx == r_len) ? S_IDLE : S_REQ;
      S_REQ:  if (w_strobe) w_next = S_WAIT;
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------- FSM: outputs
  always_comb begin
    w_dsb = 1'b0;
    if (r_state == S_REQ) w_dsb = 1'b1;
  end

  // ------------------------------------------------------- packet datapath
  always_ff @(posedge CLK) begin
    if (RES) begin
      r_cmd <= 8'h00;
      r_len <= 3'd0;
      r_idx <= 3'd0;
      r_ack <= '0;
      for (int i = 0; i < 3; i++) r_buf[i] <= 8'h00;
    end else begin
      // ack timer runs only while waiting and clears on every exit
      r_ack <= (r_state == S_WAIT && !w_ack_done) ? r_ack + 1'b1 : '0;
      if (r_state == S_IDLE && w_strobe && w_known) begin
        r_cmd <= PA_I;
        r_len <= w_len;
        r_idx <= 3'd1;
      end else if (r_state == S_REQ && w_strobe) begin
        case (r_idx)
          3'd1:    r_buf[0] <= PA_I;
          3'd2:    r_buf[1] <= PA_I;
          default: r_buf[2] <= PA_I;
        endcase
        r_idx <= r_idx + 3'd1;
      end
    end
  end

  // -------------------------------------------------------- tone generator
  assign w_tick = (r_pre == PW'(PRESCALE - 1));

  always_ff @(posedge CLK) begin
    if (RES) begin
      r_en    <= 1'b0;
      r_p     <= 8'h00;
      r_v     <= 5'd0;
      r_pre   <= '0;
      r_pcnt  <= 8'h00;
      r_phase <= 1'b0;
`ifdef UPD1771C_NOISE_EN
      r_noise <= 1'b0;
      r_lfsr  <= 15'h7FFF;
`endif
    end else if (w_commit) begin
      // Parameters land together; generator restarts on the high half.
      r_pre   <= '0;
      r_phase <= 1'b1;
      r_pcnt  <= r_p;
      case (r_cmd)
        8'h02: begin
          r_en   <= r_buf[0][7];
          r_p    <= r_buf[1];
          r_pcnt <= r_buf[1];
          r_v    <= r_buf[2][4:0];
`ifdef UPD1771C_NOISE_EN
          r_noise <= 1'b0;
`endif
        end
`ifdef UPD1771C_NOISE_EN
        8'h01: begin
          r_en    <= 1'b1;
          r_v     <= r_buf[0][4:0];
          r_noise <= 1'b1;
          r_lfsr  <= 15'h7FFF;
        end
`endif
        default: begin
          r_en <= 1'b0;
`ifdef UPD1771C_NOISE_EN
          r_noise <= 1'b0;
`endif
        end
      endcase
    end else if (w_tick) begin
      r_pre <= '0;
      if (r_pcnt == 8'h00) begin
        r_phase <= ~r_phase;
        r_pcnt  <= r_p;
      end else begin
        r_pcnt  <= r_pcnt - 8'h01;
      end
`ifdef UPD1771C_NOISE_EN
      r_lfsr <= {r_lfsr[13:0], r_lfsr[14] ^ r_lfsr[13]};
`endif
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

`ifdef UPD1771C_NOISE_EN
  assign w_ph = r_noise ? r_lfsr[0] : r_phase;
`else
  assign w_ph = r_phase;
`endif

  // ---------------------------------------------------------------- output
  always_ff @(posedge CLK) begin
    if (RES)       r_snd <= 8'h80;
    else if (!r_en) r_snd <= 8'h80;
    else if (w_ph) r_snd <= 8'h80 + {1'b0, r_v, 2'b00};
    else           r_snd <= 8'h80 - {1'b0, r_v, 2'b00};
  end

endmodule

// File: tb/tb_upd_1771c.sv
// Directed bench for upd_1771c with default parameters (PRESCALE=32,
// ACK_DELAY=16). Host bytes are driven on the falling clock edge and held
// for 4 CLK; outputs are sampled on the falling edge.
// Expected timing, counted in falling edges from the one that drives a byte:
// strobe registers on rising edge 3, DSB rises after rising edge 19
// (3 + ACK_DELAY), a final byte commits on edge 19 and SND moves after edge 20.
module tb_upd_1771c;

  logic       CLK = 1'b0;
  logic       RES;
  logic       CH1 = 1'b1;
  logic       CH2 = 1'b0;
  logic [7:0] PA_I;
  logic [7:0] PB_I;
  wire  [7:0] PA_O, PA_OE, PB_O, PB_OE, SND;

  int vec  = 0;
  int miss = 0;
  int c;

  upd_1771c dut (
    .CLK(CLK), .RES(RES), .CH1(CH1), .CH2(CH2),
    .PA_I(PA_I), .PA_O(PA_O), .PA_OE(PA_OE),
    .PB_I(PB_I), .PB_O(PB_O), .PB_OE(PB_OE),
    .SND(SND)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // drive a byte with nCS/nWR low for 4 CLK; returns at falling edge 4
  task automatic drive(input logic [7:0] b);
    @(negedge CLK);
    PA_I = b;
    PB_I = 8'h3F;
    repeat (4) @(negedge CLK);
    PB_I = 8'hFF;
  endtask

  // falling edges from the drive edge until DSB=1, capped at 60
  task automatic wait_dsb(output int cyc);
    cyc = 4;
    while (PB_O[0] !== 1'b1 && cyc < 60) begin
      @(negedge CLK);
      cyc++;
    end
  endtask

  task automatic byte_req(input logic [7:0] b, input string tag);
    int n;
    drive(b);
    wait_dsb(n);
    chk(tag, n, 19);
  endtask

  task automatic byte_ign(input logic [7:0] b, input string tag);
    int n;
    drive(b);
    wait_dsb(n);
    chk(tag, n, 60);
  endtask

  // final byte: DSB must stay low; SND holds until edge 19 and shows the
  // committed level at edge 20
  task automatic byte_last(input logic [7:0] b, input string tag,
                           input bit chk_old, input logic [7:0] old_v,
                           input logic [7:0] new_v);
    logic seen = 1'b0;
    drive(b);
    for (int i = 5; i <= 20; i++) begin
      @(negedge CLK);
      seen |= PB_O[0];
      if (i == 19 && chk_old) chk({tag, "_hold"}, SND, old_v);
    end
    chk({tag, "_snd"}, SND, new_v);
    chk({tag, "_nodsb"}, seen, 0);
  endtask

  // falling edges until SND changes, capped at 6000
  task automatic hp(output int cyc);
    logic [7:0] r;
    r   = SND;
    cyc = 0;
    while (SND === r && cyc < 6000) begin
      @(negedge CLK);
      cyc++;
    end
  endtask

  initial begin
    PA_I = 8'h00;
    PB_I = 8'hFF;
    RES  = 1'b1;
    repeat (3) @(negedge CLK);
    RES = 1'b0;
    repeat (192) @(negedge CLK);   // 32 us at 6 MHz
    chk("rst_pbo",  PB_O,  8'h00);
    chk("rst_snd",  SND,   8'h80);
    chk("rst_pboe", PB_OE, 8'h01);
    chk("rst_paoe", PA_OE, 8'h00);
    chk("rst_pao",  PA_O,  8'h00);

    // tone P=0x35, V=0x15: 0x80 +/- 0x54, half-period 32*54
    byte_req(8'h02, "p1_cmd");
    byte_req(8'h80, "p1_ctrl");
    byte_req(8'h35, "p1_per");
    byte_last(8'h15, "p1_vol", 1'b1, 8'h80, 8'hD4);
    hp(c);
    chk("p1_hp1", c, 1728);
    chk("p1_lo",  SND, 8'h2C);
    hp(c);
    chk("p1_hp2", c, 1728);
    chk("p1_hi",  SND, 8'hD4);
    chk("p1_dsb", PB_O, 8'h00);

    // P=0x4F: old tone must keep running until the fourth byte
    byte_req(8'h02, "p2_cmd");
    byte_req(8'h80, "p2_ctrl");
    byte_req(8'h4F, "p2_per");
    hp(c);
    hp(c);
    chk("p2_old_hp", c, 1728);
    byte_last(8'h15, "p2_vol", 1'b0, 8'h00, 8'hD4);
    hp(c);
    chk("p2_hp", c, 2560);
    chk("p2_lo", SND, 8'h2C);

    // ctrl[7]=0 disables, then explicit silence
    byte_req(8'h02, "p3_cmd");
    byte_req(8'h00, "p3_ctrl");
    byte_req(8'h35, "p3_per");
    byte_last(8'h15, "p3_vol", 1'b0, 8'h00, 8'h80);
    repeat (2000) @(negedge CLK);
    chk("p3_quiet", SND, 8'h80);
    byte_last(8'h00, "p4_sil", 1'b1, 8'h80, 8'h80);

    // reset mid-packet discards the partial packet
    byte_req(8'h02, "r_cmd");
    byte_req(8'h80, "r_ctrl");
    @(negedge CLK); RES = 1'b1;
    @(negedge CLK); RES = 1'b0;
    chk("r_dsb", PB_O, 8'h00);
    chk("r_snd", SND,  8'h80);
    repeat (40) @(negedge CLK);
    chk("r_idle", PB_O, 8'h00);
    byte_req(8'h02, "r2_cmd");
    byte_req(8'h80, "r2_ctrl");
    byte_req(8'h35, "r2_per");
    byte_last(8'h15, "r2_vol", 1'b1, 8'h80, 8'hD4);
    hp(c);
    chk("r2_hp", c, 1728);
    chk("r2_lo", SND, 8'h2C);

    byte_ign(8'h7F, "unk_7f");

`ifdef UPD1771C_NOISE_EN
    begin
      int n_hi = 0, n_lo = 0, n_bad = 0;
      byte_req(8'h01, "nz_cmd");
      byte_last(8'h1F, "nz_vol", 1'b0, 8'h00, 8'hFC);
      for (int i = 0; i < 3000; i++) begin
        @(negedge CLK);
        if (SND === 8'hFC) n_hi++;
        else if (SND === 8'h04) n_lo++;
        else n_bad++;
      end
      chk("nz_bad", n_bad, 0);
      chk("nz_hi_seen", n_hi > 0, 1);
      chk("nz_lo_seen", n_lo > 0, 1);
    end
`else
    byte_ign(8'h01, "cmd01_ign");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
